// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter:
// FSM state encoding, requester ids and default widths.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int MAX_IF_WAIT_DEF = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_fixed_prio_starve.sv
// Winner select between IF and DM (DM preferred) with an IF starvation
// counter that forces IF ahead after MAX_IF_WAIT consecutive DM wins.
// Ports: clk, rst (async, active-low); arb_en_i (arbiter idle);
// if_req_i (raw IF request); if_elig_i / dm_elig_i (eligible requests);
// grant_vld_o / grant_id_o (combinational winner).
module arb_fixed_prio_starve
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_IF_WAIT = MAX_IF_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en_i,
    input  logic if_req_i,
    input  logic if_elig_i,
    input  logic dm_elig_i,
    output logic grant_vld_o,
    output logic grant_id_o
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_IF_WAIT);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             force_if;

    assign force_if = (wait_cnt_q == MAX_C);

    always_comb begin
        grant_vld_o = arb_en_i & (if_elig_i | dm_elig_i);
        grant_id_o  = REQ_DM;
        if (if_elig_i & (~dm_elig_i | force_if)) begin
            grant_id_o = REQ_IF;
        end
    end

    // Only DM wins that actually bypass a waiting IF count toward starvation.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!if_req_i || (grant_vld_o && grant_id_o == REQ_IF)) begin
            wait_cnt_d = '0;
        end else if (grant_vld_o && grant_id_o == REQ_DM && if_elig_i
                     && wait_cnt_q < MAX_C) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Ports: IF (if_req/if_addr -> if_rdata/if_done/stall_if), DM (dm_req/dm_we/
// dm_addr/dm_wdata -> dm_rdata/dm_done/stall_dm), memory (mem_req/mem_we/
// mem_addr/mem_wdata <- mem_ack/mem_rdata), sticky spurious_ack error.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_IF_WAIT = MAX_IF_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              stall_if,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              stall_dm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              spurious_ack
);

    arb_state_e        state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_done_q;
    logic              dm_done_q;
    logic              spurious_q;

    logic if_elig;
    logic dm_elig;
    logic grant_vld;
    logic grant_id;

    // A request still high in its own done cycle is the old one; skip it.
    assign if_elig = if_req & ~if_done_q;
    assign dm_elig = dm_req & ~dm_done_q;

    arb_fixed_prio_starve #(
        .MAX_IF_WAIT (MAX_IF_WAIT)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .arb_en_i    (state_q == IDLE),
        .if_req_i    (if_req),
        .if_elig_i   (if_elig),
        .dm_elig_i   (dm_elig),
        .grant_vld_o (grant_vld),
        .grant_id_o  (grant_id)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (mem_ack) begin
                        spurious_q <= 1'b1;
                    end
                    if (grant_vld) begin
                        mem_req_q <= 1'b1;
                        if (grant_id == REQ_IF) begin
                            state_q     <= BUSY_IF;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                        end else begin
                            state_q     <= BUSY_DM;
                            mem_we_q    <= dm_we;
                            mem_addr_q  <= dm_addr;
                            mem_wdata_q <= dm_wdata;
                        end
                    end
                end
                BUSY_IF: begin
                    if (mem_ack) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        if_done_q  <= 1'b1;
                        if_rdata_q <= mem_rdata;
                    end
                end
                BUSY_DM: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        dm_done_q <= 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_q <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign if_rdata     = if_rdata_q;
    assign dm_rdata     = dm_rdata_q;
    assign if_done      = if_done_q;
    assign dm_done      = dm_done_q;
    assign spurious_ack = spurious_q;
    assign stall_if     = if_req & ~if_done_q;
    assign stall_dm     = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference
// model, per-cycle compare, directed scenarios and randomized traffic.
module tb_mem_port_arbiter;

    localparam int MAXW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req = 0;
    logic [31:0] if_addr = 0;
    logic [31:0] if_rdata;
    logic        if_done, stall_if;
    logic        dm_req = 0, dm_we = 0;
    logic [31:0] dm_addr = 0, dm_wdata = 0;
    logic [31:0] dm_rdata;
    logic        dm_done, stall_dm;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 0;
    logic [31:0] mem_rdata = 0;
    logic        spurious_ack;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_IF_WAIT(MAXW)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .stall_if(stall_if),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .stall_dm(stall_dm),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .spurious_ack(spurious_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          m_own = 0;   // 0 none, 1 IF, 2 DM
    int          m_wait = 0;
    logic        m_if_done = 0, m_dm_done = 0, m_req = 0, m_we = 0, m_spur = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_if_rd = 0, m_dm_rd = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_own = 0; m_wait = 0; m_if_done = 0; m_dm_done = 0;
            m_req = 0; m_we = 0; m_spur = 0;
            m_addr = 0; m_wdata = 0; m_if_rd = 0; m_dm_rd = 0;
        end else begin
            bit ife, dme;
            int g;
            ife = if_req && !m_if_done;
            dme = dm_req && !m_dm_done;
            m_if_done = 0;
            m_dm_done = 0;
            g = 0;
            if (m_own == 0) begin
                if (mem_ack) m_spur = 1;
                if (ife && dme) g = (m_wait == MAXW) ? 1 : 2;
                else if (ife) g = 1;
                else if (dme) g = 2;
                if (g == 1) begin
                    m_own = 1; m_req = 1; m_we = 0;
                    m_addr = if_addr; m_wdata = 0;
                end else if (g == 2) begin
                    m_own = 2; m_req = 1; m_we = dm_we;
                    m_addr = dm_addr; m_wdata = dm_wdata;
                end
            end else if (mem_ack) begin
                if (m_own == 1) begin
                    m_if_done = 1; m_if_rd = mem_rdata;
                end else begin
                    m_dm_done = 1;
                    if (!m_we) m_dm_rd = mem_rdata;
                end
                m_own = 0; m_req = 0; m_we = 0;
            end
            if (!if_req || g == 1) m_wait = 0;
            else if (g == 2 && ife && m_wait < MAXW) m_wait++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("if_done", 32'(if_done), 32'(m_if_done));
            chk("dm_done", 32'(dm_done), 32'(m_dm_done));
            chk("mem_req", 32'(mem_req), 32'(m_req));
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("if_rdata", if_rdata, m_if_rd);
            chk("dm_rdata", dm_rdata, m_dm_rd);
            chk("spurious", 32'(spurious_ack), 32'(m_spur));
            chk("stall_if", 32'(stall_if), 32'(if_req & ~m_if_done));
            chk("stall_dm", 32'(stall_dm), 32'(dm_req & ~m_dm_done));
        end
    end

    // ---------------- memory responder ----------------
    bit          mem_auto = 1, mem_data_rand = 1, spur_en = 0, armed = 0;
    int          mem_wait_fix = -1, cnt = 0;
    logic [31:0] mem_data_fix = 0;

    always @(posedge clk) begin
        #1;
        if (!mem_req) armed = 0;
        if (mem_auto) begin
            if (mem_ack) begin
                mem_ack = 0;
            end else if (mem_req) begin
                if (!armed) begin
                    armed = 1;
                    cnt = (mem_wait_fix < 0) ? int'($urandom_range(3, 0)) : mem_wait_fix;
                end
                if (cnt == 0) begin
                    mem_ack = 1;
                    mem_rdata = mem_data_rand ? $urandom : mem_data_fix;
                    armed = 0;
                end else begin
                    cnt--;
                end
            end else if (spur_en && $urandom_range(39, 0) == 0) begin
                mem_ack = 1;
            end
        end
    end

    // ---------------- requesters ----------------
    bit rnd_on = 0;

    always @(posedge clk) begin
        #1;
        if (if_req && if_done) begin
            if (rnd_on && $urandom_range(2, 0) == 0) if_addr = $urandom;
            else if_req = 0;
        end else if (!if_req && rnd_on && $urandom_range(3, 0) == 0) begin
            if_req = 1; if_addr = $urandom;
        end
    end

    always @(posedge clk) begin
        #1;
        if (dm_req && dm_done) begin
            if (rnd_on && $urandom_range(2, 0) == 0) begin
                dm_addr = $urandom; dm_we = 1'($urandom); dm_wdata = $urandom;
            end else begin
                dm_req = 0;
            end
        end else if (!dm_req && rnd_on && $urandom_range(2, 0) == 0) begin
            dm_req = 1; dm_addr = $urandom;
            dm_we = 1'($urandom); dm_wdata = $urandom;
        end
    end

    // ---------------- directed sequence ----------------
    int          n_st, n_dn, n_rise, dn_at, n_good, n_st2, dm_at, if_at, g_at;
    logic        prev;
    logic [31:0] rd, a0;

    initial begin
        rst = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_done", 32'({if_done, dm_done}), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rdata", if_rdata | dm_rdata, 0);
        chk("rst_spur", 32'(spurious_ack), 0);
        @(posedge clk); #1; rst = 1;

        // IF read, immediate ack
        mem_data_rand = 0; mem_wait_fix = 0; mem_data_fix = 32'h2010_0005;
        @(posedge clk); #1; if_addr = 32'h40; if_req = 1;
        n_st = 0; n_dn = 0; n_rise = 0; dn_at = 0; prev = 0; rd = 0; a0 = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (stall_if) n_st++;
            if (if_done) begin n_dn++; dn_at = i; rd = if_rdata; end
            if (mem_req && !prev) begin n_rise++; a0 = mem_addr; end
            prev = mem_req;
        end
        chk("t1_stall_cycles", n_st, 2);
        chk("t1_done_cnt", n_dn, 1);
        chk("t1_done_at", dn_at, 3);
        chk("t1_rdata", rd, 32'h2010_0005);
        chk("t1_mem_req_cnt", n_rise, 1);
        chk("t1_addr", a0, 32'h40);

        // DM write, 3 wait states
        mem_wait_fix = 3;
        @(posedge clk); #1;
        dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_we = 1; dm_req = 1;
        n_st = 0; n_dn = 0; n_good = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_req) n_st++;
            if (mem_req && mem_we && mem_addr == 32'h100
                && mem_wdata == 32'hDEAD_BEEF) n_good++;
            if (dm_done) n_dn++;
        end
        chk("t2_req_cycles", n_st, 4);
        chk("t2_stable_cycles", n_good, 4);
        chk("t2_done_cnt", n_dn, 1);
        chk("t2_dm_rdata", dm_rdata, 0);
        chk("t2_if_rdata", if_rdata, 32'h2010_0005);

        // DM read arrives while IF is busy
        mem_wait_fix = 0; mem_data_fix = 32'h1234_5678; dm_we = 0;
        @(posedge clk); #1; if_addr = 32'h80; if_req = 1;
        @(posedge clk); #1; dm_addr = 32'h200; dm_req = 1;
        n_st2 = 0; dm_at = 0; if_at = 0; g_at = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (stall_dm) n_st2++;
            if (if_done) if_at = i;
            if (dm_done) dm_at = i;
            if (mem_req && mem_addr == 32'h200 && g_at == 0) g_at = i;
        end
        chk("t4_if_done_at", if_at, 2);
        chk("t4_dm_grant_at", g_at, 3);
        chk("t4_dm_done_at", dm_at, 4);
        chk("t4_stall_dm", n_st2, 3);
        chk("t4_dm_rdata", dm_rdata, 32'h1234_5678);

        // random traffic
        mem_data_rand = 1; mem_wait_fix = -1; rnd_on = 1;
        repeat (2000) @(posedge clk);
        #1; rnd_on = 0;
        repeat (20) @(posedge clk);

        // reset in BUSY_DM, late ack after release
        mem_auto = 0;
        @(posedge clk); #1; mem_ack = 0;
        dm_we = 0; dm_addr = 32'h300; dm_req = 1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 0; dm_req = 0;
        @(negedge clk);
        chk("t5_rst_mem_req", 32'(mem_req), 0);
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; mem_ack = 1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("t5_no_done_a", 32'(dm_done), 0);
        @(posedge clk); #1; mem_ack = 0;
        @(negedge clk);
        chk("t5_no_done_b", 32'(dm_done), 0);
        chk("t5_spurious", 32'(spurious_ack), 1);
        chk("t5_idle", 32'(mem_req), 0);
        chk("t5_dm_rdata", dm_rdata, 0);

        // random traffic with stray acks
        mem_auto = 1; spur_en = 1; rnd_on = 1;
        repeat (2000) @(posedge clk);
        #1; rnd_on = 0; spur_en = 0;
        repeat (20) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
